// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for the MEM stage: drives a word-addressed data memory
// from byte-addressed load/store requests. Sub-word stores use read-modify-write.
module lsu_mem_initiator #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MEM_DEPTH = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic             resp_err,
    output logic [WIDTH-1:0] resp_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_wen,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int unsigned IDX_W = WIDTH - 2;
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       lane_q, lane_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0] merge_q, merge_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             valid_q, valid_d;
    logic             wen_q, wen_d;
    logic             ready_q, ready_d;

    logic             misaligned_c;
    logic             out_of_range_c;
    logic [7:0]       byte_c;
    logic [15:0]      half_c;

    // Request legality, evaluated on the incoming (not yet latched) request
    always_comb begin
        misaligned_c = 1'b0;
        case (req_size)
            SZ_BYTE: misaligned_c = 1'b0;
            SZ_HALF: misaligned_c = req_addr[0];
            SZ_WORD: misaligned_c = (req_addr[1:0] != 2'b00);
            default: misaligned_c = 1'b1;
        endcase
        out_of_range_c = (req_addr[WIDTH-1:2] >= DEPTH_IDX);
    end

    // Lane extraction from the memory word for the latched byte/half position
    always_comb begin
        byte_c = mem_rdata[{lane_q, 3'b000} +: 8];
        half_c = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    end

    // Next-state and next-register logic; outputs follow the next state
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        addr_d  = addr_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    lane_d  = req_addr[1:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata[15:0];
                    addr_d  = {2'b00, req_addr[WIDTH-1:2]};
                    if (misaligned_c || out_of_range_c) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_DONE;
                    end else if (!req_write) begin
                        state_d = ST_LOAD;
                    end else if (req_size == SZ_WORD) begin
                        merge_d = req_wdata;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RMW_READ;
                    end
                end
            end
            ST_LOAD: begin
                case (size_q)
                    SZ_BYTE: rdata_d = {{(WIDTH-8){byte_c[7] & ~uns_q}}, byte_c};
                    SZ_HALF: rdata_d = {{(WIDTH-16){half_c[15] & ~uns_q}}, half_c};
                    default: rdata_d = mem_rdata;
                endcase
                err_d   = 1'b0;
                state_d = ST_DONE;
            end
            ST_RMW_READ: begin
                merge_d = mem_rdata;
                if (size_q == SZ_BYTE) begin
                    merge_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
                end else begin
                    merge_d[{lane_q[1], 4'b0000} +: 16] = wdata_q;
                end
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                err_d   = 1'b0;
                rdata_d = '0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_DONE);
        wen_d   = (state_d == ST_WRITE);
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            merge_q <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            wen_q   <= wen_d;
            ready_q <= ready_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = merge_q;
    assign mem_wen    = wen_q;

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator for the MEM stage of the pipelined MIPS core.
- Takes byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests from the pipeline and drives the word-addressed, async-read, sync-write data memory port.
- Sub-word stores use read-modify-write.
- Flags misaligned and out-of-range accesses; the pipeline stalls while the unit is busy.

Parameters:
- WIDTH, 32, data/address width; byte-lane logic is defined for 32 only.
- MEM_DEPTH, 100, number of words in the data memory; word index >= MEM_DEPTH is out of range.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as misaligned.
- req_unsigned  in  1  zero-extend loads (lbu/lhu); ignored for word and store.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_err  out  1  valid with resp_valid: misaligned or out of range, no memory write done.
- resp_rdata  out  WIDTH  extended load data; 0 for stores and errors.
- mem_addr  out  WIDTH  word index = {2'b00, addr[31:2]}.
- mem_wdata  out  WIDTH  full word to write.
- mem_wen  out  1  memory write enable.
- mem_rdata  in  WIDTH  memory read data, combinational from mem_addr.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; resp_valid, resp_err, mem_wen = 0; resp_rdata, mem_addr, mem_wdata = 0. This holds from any state; a pending write is abandoned with mem_wen low on the next cycle.
- Handshake: a request is accepted on an edge where req_valid && req_ready. Address, size, unsigned, write and wdata are latched. Inputs are don't-care afterwards.
- Error check at accept:
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size 11.
  - Out of range: addr[31:2] >= MEM_DEPTH.
  - Either case -> DONE with resp_err=1. No memory access and mem_wen stays 0.
- States:
  - IDLE: req_ready=1, mem_wen=0. On accept: error -> DONE; load -> LOAD; word store -> WRITE; byte/half store -> RMW_READ.
  - LOAD: mem_addr driven. Lane select (little-endian): byte lane = addr[1:0], half lane = addr[1]. Sign- or zero-extend into resp_rdata -> DONE.
  - RMW_READ: capture mem_rdata. Replace the selected byte lane with wdata[7:0], or the half lane with wdata[15:0]. Store the result in the merge register -> WRITE.
  - WRITE: mem_wen=1 for exactly this one cycle; mem_wdata = merge register (word store: wdata unchanged) -> DONE.
  - DONE: resp_valid=1 for one cycle; resp_err as decided; then -> IDLE. req_ready=0.
- Cycles from the accept edge to the resp_valid cycle:
  - error: 1
  - load: 2
  - word store: 2
  - sub-word store: 3
  - Back-to-back requests: the next accept is possible on the cycle after DONE.
- mem_addr holds the latched word index from accept until the next accept; it is 0 only after reset.
- resp_rdata and resp_err hold their value until the next DONE.
- Outputs are Moore-decoded from state and registers; no combinational path from req_* to mem_* or resp_*.

Test Plan:
- Reset mid-operation: reset asserted while in WRITE -> next cycle mem_wen=0, state IDLE, req_ready=1, all outputs zero.
- Word round trip: sw 0xDEADBEEF @0x10 -> mem_wen=1 only in the WRITE cycle, mem_addr=4; then lw @0x10 -> resp_valid 2 cycles after accept, resp_rdata=0xDEADBEEF, resp_err=0.
- Byte loads with word 0x80FF7F01 @0x0:
  - lb @0x3 -> 0xFFFFFF80.
  - lbu @0x3 -> 0x00000080.
  - lb @0x2 -> 0xFFFFFFFF.
  - lh @0x0 -> 0x00007F01.
  - lhu @0x2 -> 0x000080FF.
- Sub-word RMW, word 0x11223344 @0x8:
  - sb 0xAA @0x9 -> mem_wdata=0x1122AA44.
  - Then sh 0xBEEF @0xA -> 0xBEEFAA44.
  - Each completes in 3 cycles.
- Errors, each -> resp_valid with resp_err=1, mem_wen never asserted, memory unchanged:
  - lh @0x5.
  - sw @0x6.
  - size 11.
  - lw @0x190 (word 100 with MEM_DEPTH=100).
- Back-to-back: req_valid held high with 3 queued loads -> req_ready low during LOAD/DONE, each accepted the cycle after the previous resp_valid, no request dropped or duplicated.
